fifo8_16: RTL and testbench
===========================

# fifo8_16

Eight-entry, 16-bit synchronous FIFO with valid/ready handshakes on both sides. It is the first buffering stage built on top of the gate library. It decouples a 16-bit producer from a consumer that may stall. Occupancy is tracked with one valid bit per slot, and the `empty` flag is derived by reducing those bits through the library `Or8Way` gate.

## Interface
- `WIDTH`, default 16: data word width. The depth is fixed at 8 and is not a parameter, because the flag logic reduces exactly 8 valid bits.

Ports:
- `clock`  in  1  rising-edge clock, the only clock domain.
- `reset`  in  1  asynchronous, active-high. All state clears immediately on assertion. Release is sampled on `clock`.
- `in_data`  in  WIDTH  write data.
- `in_valid`  in  1  producer offers `in_data`.
- `in_ready`  out  1  FIFO can accept a word.
- `out_data`  out  WIDTH  head-of-queue word (show-ahead).
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer takes `out_data`.
- `count`  out  4  occupancy, 0..8.
- `full`  out  1  `count` == 8.
- `empty`  out  1  `count` == 0.

## Operation
**State**
- `mem[0..7]`, WIDTH bits each. Not reset.
- `wptr`, 3 bits.
- `rptr`, 3 bits.
- `vld[7:0]`, one valid bit per slot.
- `count`, 4-bit register.

**Flags**
- `empty` = NOT `Or8Way(vld)`.
- `full` = AND of all 8 `vld` bits.
- `count` must always equal popcount(`vld`). Any mismatch is a bug that the bench must flag.

**Handshake outputs**
- `in_ready` = !`full` && !`reset`.
- `out_valid` = !`empty`.

**Events**
- Push when `in_valid && in_ready` at a rising edge:
  - `mem[wptr]` <= `in_data`
  - `vld[wptr]` <= 1
  - `wptr` <= `wptr` + 1, wrapping 7 → 0.
- Pop when `out_valid && out_ready` at a rising edge:
  - `vld[rptr]` <= 0
  - `rptr` <= `rptr` + 1, wrapping 7 → 0.

**Count update**
- Push only: +1.
- Pop only: −1.
- Both or neither: unchanged.

**Output data**
- `out_data` = `mem[rptr]` when `out_valid` = 1.
- `out_data` is forced to 0 when empty, so the output is deterministic for verification.

**Boundary rules**
- Full: `in_ready` = 0, and `in_valid` is ignored even if a pop occurs in the same cycle. There is no write-through into a slot freed that cycle; the freed slot becomes writable on the next cycle.
- Empty: `out_valid` = 0, and `out_ready` is ignored. There is no bypass: a word pushed into an empty FIFO is visible at the output on the next cycle.
- Simultaneous push and pop with 1 ≤ count ≤ 7: both take effect and `count` is unchanged. When `wptr` == `rptr` and count is nonzero, the FIFO is full, so this case cannot arise.
- Pointer wrap-around has no effect on ordering. Words always leave in the order they entered.
- Holding `in_valid` high while `in_ready` = 0 is legal. The producer must keep `in_data` stable until accepted; the FIFO does not check this.

**Reset**
- Asynchronous assertion, including mid-transfer. Immediately:
  - `wptr`, `rptr`, `vld`, `count` go to 0
  - `empty` = 1, `full` = 0
  - `out_valid` = 0, `out_data` = 0
  - `in_ready` = 0 while `reset` is high.
- Any handshake in the cycle in which reset is asserted is discarded.

## Timing
- Reset values: `in_ready` 0 during reset and 1 after release; `out_valid` 0; `out_data` 0; `count` 0; `full` 0; `empty` 1.
- Write-to-read latency: 1 cycle. A word accepted at edge N has `out_valid` = 1 after edge N.
- Flag latency: `full`, `empty`, `count`, `in_ready` and `out_valid` update after the edge that changes `vld`. They are combinational from registered state only.
- Throughput: 1 push and 1 pop per cycle when 1 ≤ count ≤ 7.
- There is no combinational path from `in_valid` or `out_ready` to any output.
- First valid edge after reset release: the first rising edge at which `reset` is low.

## Test plan
- Reset then idle: `count` = 0, `empty` = 1, `full` = 0, `in_ready` = 1, `out_valid` = 0, `out_data` = 0 across 5 cycles.
- Fill with `out_ready` = 0, pushing 0x1111..0x8888:
  - after the 8th push: `full` = 1, `count` = 8, `in_ready` = 0
  - a 9th push of 0x9999 is dropped
  - draining yields 0x1111..0x8888 in order, then `empty` = 1.
- Full plus simultaneous pop and push of 0xAAAA:
  - only the pop occurs, and `count` goes 8 → 7
  - on the next cycle 0xAAAA is accepted, and `count` goes back to 8.
- Empty plus same-cycle push of 0x1234 with `out_ready` = 1:
  - no pop that cycle
  - on the next cycle `out_valid` = 1 and `out_data` = 0x1234.
- Streaming 20 words with a random 50% `in_valid`/`out_ready` pattern, wrapping the pointers at least twice:
  - output order matches input order
  - `count` == popcount(`vld`) every cycle.
- Assert `reset` asynchronously mid-cycle with `count` = 5: all outputs take their reset values immediately, without waiting for a clock edge, and after release the first pushed word, 0xBEEF, is the first word out.

Source files
------------

// File: rtl/fifo8_16.sv
// rtl/fifo8_16.sv - eight-entry show-ahead FIFO with valid/ready on both sides
// Occupancy is one valid bit per slot; empty is the Or8Way reduction of those bits.

module Or8Way (
  input  logic [7:0] i_in,
  output logic       o_out
);
  assign o_out = |i_in;
endmodule

module fifo8_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [0:7];
  logic [2:0]       r_wptr;
  logic [2:0]       r_rptr;
  logic [7:0]       r_vld;
  logic [3:0]       r_count;

  logic             w_any_vld;
  logic             w_push;
  logic             w_pop;
  logic [7:0]       w_vld_next;
  logic [3:0]       w_count_next;

  Or8Way u_or8 (
    .i_in  (r_vld),
    .o_out (w_any_vld)
  );

  assign empty     = ~w_any_vld;
  assign full      = &r_vld;
  assign in_ready  = ~full & ~reset;
  assign out_valid = ~empty;
  assign count     = r_count;
  assign out_data  = empty ? '0 : r_mem[r_rptr];

  // in_ready already excludes full, so a pop never frees a slot for a same-cycle push
  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  always_comb begin
    w_vld_next   = r_vld;
    w_count_next = r_count;
    if (w_push) w_vld_next[r_wptr] = 1'b1;
    if (w_pop)  w_vld_next[r_rptr] = 1'b0;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 4'd1;
      2'b01:   w_count_next = r_count - 4'd1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_vld   <= '0;
      r_count <= '0;
    end else begin
      r_vld   <= w_vld_next;
      r_count <= w_count_next;
      if (w_push) r_wptr <= r_wptr + 3'd1;
      if (w_pop)  r_rptr <= r_rptr + 3'd1;
    end
  end

  // storage is deliberately left out of reset
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= in_data;
  end

endmodule

// File: tb/tb_fifo8_16.sv
// tb/tb_fifo8_16.sv - randomized and directed bench for fifo8_16 against a queue model

module tb_fifo8_16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  count;
  logic        full;
  logic        empty;

  int n_checks = 0;
  int n_errors = 0;
  int n_pushed = 0;
  int n_popped = 0;
  logic [15:0] q[$];

  fifo8_16 #(.WIDTH(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = q.size();
    chk({tag, ":count"},     {28'd0, count}, sz);
    chk({tag, ":empty"},     {31'd0, empty}, {31'd0, sz == 0});
    chk({tag, ":full"},      {31'd0, full}, {31'd0, sz == 8});
    chk({tag, ":in_ready"},  {31'd0, in_ready}, {31'd0, (sz < 8) && !reset});
    chk({tag, ":out_valid"}, {31'd0, out_valid}, {31'd0, sz > 0});
    chk({tag, ":out_data"},  {16'd0, out_data}, (sz > 0) ? {16'd0, q[0]} : 32'd0);
    chk({tag, ":popcount"},  {28'd0, count}, $countones(dut.r_vld));
  endtask

  // One clock: the model decides push/pop from the pre-edge inputs, then outputs are checked 1ns later.
  task automatic cycle(input string tag);
    bit push, pop;
    push = in_valid && (q.size() < 8) && !reset;
    pop  = out_ready && (q.size() > 0) && !reset;
    @(posedge clock);
    if (pop) begin
      void'(q.pop_front());
      n_popped++;
    end
    if (push) begin
      q.push_back(in_data);
      n_pushed++;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    int guard;
    logic [15:0] v;

    // reset held: values during reset
    @(posedge clock); #1;
    check_all("in_reset");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cycle("idle");

    // fill with consumer stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      v = 16'h1111 * k[15:0];
      in_data = v;
      cycle("fill");
    end
    chk("full_after8", {31'd0, full}, 32'd1);
    chk("count_after8", {28'd0, count}, 32'd8);
    in_data = 16'h9999;
    cycle("push9_dropped");
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      v = 16'h1111 * k[15:0];
      chk("drain_order", {16'd0, out_data}, {16'd0, v});
      cycle("drain");
    end
    chk("empty_after_drain", {31'd0, empty}, 32'd1);

    // full with simultaneous pop and push: only the pop happens
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data = 16'($urandom);
      cycle("refill");
    end
    in_data   = 16'hAAAA;
    out_ready = 1'b1;
    cycle("full_pop_push");
    chk("full_pop_count7", {28'd0, count}, 32'd7);
    out_ready = 1'b0;
    cycle("push_after_free");
    chk("refull_count8", {28'd0, count}, 32'd8);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) cycle("drain2");

    // empty with same-cycle push and pop request: no bypass
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    out_ready = 1'b1;
    cycle("empty_push");
    chk("no_bypass_data", {16'd0, out_data}, 32'h1234);
    chk("no_bypass_count", {28'd0, count}, 32'd1);
    in_valid = 1'b0;
    cycle("drain3");

    // random streaming of 20 words
    n_pushed = 0;
    n_popped = 0;
    guard = 0;
    while ((n_popped < 20) && (guard < 1000)) begin
      in_valid  = (n_pushed < 20) ? 1'($urandom) : 1'b0;
      in_data   = 16'($urandom);
      out_ready = 1'($urandom);
      cycle("stream");
      guard++;
    end
    chk("stream_pushed", n_pushed, 32'd20);
    chk("stream_popped", n_popped, 32'd20);

    // asynchronous reset mid-cycle with five words held
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_data = 16'($urandom);
      cycle("pre_reset_fill");
    end
    chk("pre_reset_count5", {28'd0, count}, 32'd5);
    #2;
    reset = 1'b1;
    q.delete();
    #1;
    check_all("async_reset");
    @(posedge clock); #1;
    check_all("reset_held");
    reset     = 1'b0;
    in_data   = 16'hBEEF;
    in_valid  = 1'b1;
    cycle("post_reset_push");
    in_valid  = 1'b0;
    chk("first_out_beef", {16'd0, out_data}, 32'hBEEF);
    out_ready = 1'b1;
    cycle("post_reset_pop");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
